// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: decodes RAM, RNG, generation counter, status and dot-location regions.
// Optional LFSR block is built only when MMIO_RNG_EN is defined; otherwise RNG_ADDR maps to RAM.
module mmio_hub #(
    parameter int unsigned RNG_ADDR   = 9990,
    parameter int unsigned SEG_ADDR   = 9991,
    parameter int unsigned STAT_ADDR  = 9992,
    parameter int unsigned DOT_X_BASE = 10240,
    parameter int unsigned DOT_Y_BASE = 12288,
    parameter int unsigned N_DOTS     = 2048,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SEG_W      = 14,
    parameter logic [31:0] RNG_SEED   = 32'h0000_0001
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic                      cpu_wren,
    output logic [31:0]               cpu_rdata,
    input  logic [31:0]               ram_rdata,
    output logic                      ram_wren,
    input  logic                      inc_seg,
    output logic [SEG_W-1:0]          seg_value,
    output logic                      dot_valid,
    input  logic                      dot_ready,
    output logic                      dot_is_y,
    output logic [$clog2(N_DOTS)-1:0] dot_id,
    output logic [31:0]               dot_loc,
    output logic                      fifo_overflow
);

    localparam int unsigned ID_W  = $clog2(N_DOTS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [31:0] RNG_A  = 32'(RNG_ADDR);
    localparam logic [31:0] SEG_A  = 32'(SEG_ADDR);
    localparam logic [31:0] STAT_A = 32'(STAT_ADDR);
    localparam logic [31:0] DX_LO  = 32'(DOT_X_BASE);
    localparam logic [31:0] DX_HI  = 32'(DOT_X_BASE + N_DOTS);
    localparam logic [31:0] DY_LO  = 32'(DOT_Y_BASE);
    localparam logic [31:0] DY_HI  = 32'(DOT_Y_BASE + N_DOTS);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    logic        sel_ram, sel_rng, sel_seg, sel_stat, sel_dotx, sel_doty;
    logic [31:0] rng_val;

    assign sel_seg  = (cpu_addr == SEG_A);
    assign sel_stat = (cpu_addr == STAT_A);
    assign sel_dotx = (cpu_addr >= DX_LO) && (cpu_addr < DX_HI);
    assign sel_doty = (cpu_addr >= DY_LO) && (cpu_addr < DY_HI);

`ifdef MMIO_RNG_EN
    logic [31:0] lfsr_q, lfsr_d;

    assign sel_ram = (cpu_addr < RNG_A);
    assign sel_rng = (cpu_addr == RNG_A);
    assign rng_val = lfsr_q;

    // A store of zero would lock the LFSR, so it falls back to the seed.
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        if (cpu_wren && sel_rng) begin
            lfsr_d = (cpu_wdata == 32'd0) ? RNG_SEED : cpu_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= RNG_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign sel_ram = (cpu_addr <= RNG_A);
    assign sel_rng = 1'b0;
    assign rng_val = 32'd0;
`endif

    assign ram_wren = cpu_wren && sel_ram;

    // Generation counter: inc_seg is registered, then edge-detected against its previous sample.
    logic             inc_q, inc_prev_q;
    logic [SEG_W-1:0] seg_q, seg_d;

    always_comb begin
        seg_d = seg_q;
        if (cpu_wren && sel_seg) begin
            seg_d = cpu_wdata[SEG_W-1:0];
        end else if (inc_q && !inc_prev_q) begin
            seg_d = seg_q + SEG_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inc_q      <= 1'b0;
            inc_prev_q <= 1'b0;
            seg_q      <= '0;
        end else begin
            inc_q      <= inc_seg;
            inc_prev_q <= inc_q;
            seg_q      <= seg_d;
        end
    end

    assign seg_value = seg_q;

    // Dot FIFO, first-word-fall-through. Handshake: an entry transfers on a cycle
    // where dot_valid and dot_ready are both high; the head holds while !dot_ready.
    logic             mem_y_q   [FIFO_DEPTH];
    logic [ID_W-1:0]  mem_id_q  [FIFO_DEPTH];
    logic [31:0]      mem_loc_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             fifo_full, fifo_empty;
    logic             push_req, push_acc, pop;
    logic [ID_W-1:0]  push_id;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = cpu_wren && (sel_dotx || sel_doty);
    assign pop        = !fifo_empty && dot_ready;
    assign push_acc   = push_req && (!fifo_full || pop);
    assign push_id    = sel_doty ? ID_W'(cpu_addr - DY_LO) : ID_W'(cpu_addr - DX_LO);

    always_comb begin
        count_d = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A dropped push outranks a simultaneous clear so no overflow event is lost.
    always_comb begin
        ovf_d = ovf_q;
        if (cpu_wren && sel_stat && cpu_wdata[0]) begin
            ovf_d = 1'b0;
        end
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_y_q[i]   <= 1'b0;
                mem_id_q[i]  <= '0;
                mem_loc_q[i] <= '0;
            end
        end else begin
            if (push_acc) begin
                mem_y_q[wr_ptr_q]   <= sel_doty;
                mem_id_q[wr_ptr_q]  <= push_id;
                mem_loc_q[wr_ptr_q] <= cpu_wdata;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dot_valid     = !fifo_empty;
    assign dot_is_y      = mem_y_q[rd_ptr_q];
    assign dot_id        = mem_id_q[rd_ptr_q];
    assign dot_loc       = mem_loc_q[rd_ptr_q];
    assign fifo_overflow = ovf_q;

    // Status count field saturates at 15 for deep FIFOs.
    logic [31:0] cnt_ext;
    logic [3:0]  stat_cnt;

    assign cnt_ext  = 32'(count_q);
    assign stat_cnt = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];

    always_comb begin
        cpu_rdata = 32'd0;
        if (sel_ram) begin
            cpu_rdata = ram_rdata;
        end else if (sel_rng) begin
            cpu_rdata = rng_val;
        end else if (sel_seg) begin
            cpu_rdata = 32'(seg_q);
        end else if (sel_stat) begin
            cpu_rdata = {27'd0, stat_cnt, ovf_q};
        end
    end

endmodule

// File: tb/tb_mmio_hub.sv
// Bench for mmio_hub: directed literal checks plus randomized traffic compared every cycle
// against a queue-based behavioural model. Follows MMIO_RNG_EN the same way as the design.
module tb_mmio_hub;

    localparam int unsigned RNG_ADDR   = 9990;
    localparam int unsigned SEG_ADDR   = 9991;
    localparam int unsigned STAT_ADDR  = 9992;
    localparam int unsigned DOT_X_BASE = 10240;
    localparam int unsigned DOT_Y_BASE = 12288;
    localparam int unsigned N_DOTS     = 2048;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned SEG_W      = 14;
    localparam logic [31:0] SEED       = 32'h0000_0001;
    localparam int unsigned ID_W       = $clog2(N_DOTS);
    localparam longint unsigned SEG_MOD = 64'd1 << SEG_W;
`ifdef MMIO_RNG_EN
    localparam bit RNG_EN = 1'b1;
`else
    localparam bit RNG_EN = 1'b0;
`endif

    localparam int R_RAM = 0, R_RNG = 1, R_SEG = 2, R_STAT = 3, R_DOTX = 4, R_DOTY = 5, R_NONE = 6;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [31:0]     cpu_addr = '0;
    logic [31:0]     cpu_wdata = '0;
    logic            cpu_wren = 1'b0;
    logic [31:0]     cpu_rdata;
    logic [31:0]     ram_rdata = '0;
    logic            ram_wren;
    logic            inc_seg = 1'b0;
    logic [SEG_W-1:0] seg_value;
    logic            dot_valid;
    logic            dot_ready = 1'b0;
    logic            dot_is_y;
    logic [ID_W-1:0] dot_id;
    logic [31:0]     dot_loc;
    logic            fifo_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_hub #(
        .RNG_ADDR(RNG_ADDR), .SEG_ADDR(SEG_ADDR), .STAT_ADDR(STAT_ADDR),
        .DOT_X_BASE(DOT_X_BASE), .DOT_Y_BASE(DOT_Y_BASE), .N_DOTS(N_DOTS),
        .FIFO_DEPTH(FIFO_DEPTH), .SEG_W(SEG_W), .RNG_SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren), .cpu_rdata(cpu_rdata),
        .ram_rdata(ram_rdata), .ram_wren(ram_wren),
        .inc_seg(inc_seg), .seg_value(seg_value),
        .dot_valid(dot_valid), .dot_ready(dot_ready), .dot_is_y(dot_is_y),
        .dot_id(dot_id), .dot_loc(dot_loc), .fifo_overflow(fifo_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a < RNG_ADDR) return R_RAM;
        if (a == RNG_ADDR) return RNG_EN ? R_RNG : R_RAM;
        if (a == SEG_ADDR) return R_SEG;
        if (a == STAT_ADDR) return R_STAT;
        if (a >= DOT_X_BASE && a < DOT_X_BASE + N_DOTS) return R_DOTX;
        if (a >= DOT_Y_BASE && a < DOT_Y_BASE + N_DOTS) return R_DOTY;
        return R_NONE;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Behavioural model: queue of dots, integer counter, history of sampled inc_seg.
    typedef struct {
        bit          is_y;
        int unsigned id;
        logic [31:0] loc;
    } dot_t;

    dot_t            m_q[$];
    logic [31:0]     m_lfsr;
    longint unsigned m_seg;
    bit              m_hist1, m_hist2;
    bit              m_ov;
    bit              m_pristine;
    int              m_r;
    bit              m_pop, m_push, m_full;
    dot_t            m_ent;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_lfsr = SEED;
            m_seg = 0;
            m_hist1 = 0;
            m_hist2 = 0;
            m_ov = 0;
            m_pristine = 1;
        end else begin
            m_r = region(cpu_addr);
            if (RNG_EN) begin
                if (cpu_wren && m_r == R_RNG) m_lfsr = (cpu_wdata == 0) ? SEED : cpu_wdata;
                else m_lfsr = lfsr_next(m_lfsr);
            end
            // inc_seg seen high one sample ago and low two samples ago
            if (cpu_wren && m_r == R_SEG) m_seg = longint'(cpu_wdata) % SEG_MOD;
            else if (m_hist1 && !m_hist2) m_seg = (m_seg + 1) % SEG_MOD;
            m_hist2 = m_hist1;
            m_hist1 = inc_seg;
            m_pop  = (m_q.size() > 0) && dot_ready;
            m_push = cpu_wren && (m_r == R_DOTX || m_r == R_DOTY);
            m_full = (m_q.size() == FIFO_DEPTH);
            if (m_pop) void'(m_q.pop_front());
            if (m_push && m_q.size() < FIFO_DEPTH) begin
                m_ent.is_y = (m_r == R_DOTY);
                m_ent.id   = cpu_addr - (m_ent.is_y ? DOT_Y_BASE : DOT_X_BASE);
                m_ent.loc  = cpu_wdata;
                m_q.push_back(m_ent);
                m_pristine = 0;
            end
            if (m_push && m_full && !m_pop) m_ov = 1;
            else if (cpu_wren && m_r == R_STAT && cpu_wdata[0]) m_ov = 0;
        end
    end

    function automatic logic [31:0] exp_rdata();
        int r;
        int unsigned c;
        r = region(cpu_addr);
        c = (m_q.size() > 15) ? 15 : m_q.size();
        case (r)
            R_RAM:  return ram_rdata;
            R_RNG:  return m_lfsr;
            R_SEG:  return 32'(m_seg);
            R_STAT: return (c << 1) | 32'(m_ov);
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            chk("cmp_rdata", cpu_rdata, exp_rdata());
            chk("cmp_ram_wren", ram_wren, cpu_wren && region(cpu_addr) == R_RAM);
            chk("cmp_seg", seg_value, m_seg);
            chk("cmp_overflow", fifo_overflow, m_ov);
            chk("cmp_valid", dot_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("cmp_is_y", dot_is_y, m_q[0].is_y);
                chk("cmp_id", dot_id, m_q[0].id);
                chk("cmp_loc", dot_loc, m_q[0].loc);
            end else if (m_pristine) begin
                chk("cmp_head_zero", {dot_is_y, dot_id, dot_loc}, 0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wren  = 1'b1;
        step();
        cpu_wren  = 1'b0;
    endtask

    task automatic rand_cycle(input int ready_pct);
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0, 1: cpu_addr = $urandom_range(0, RNG_ADDR - 1);
            2:    cpu_addr = RNG_ADDR;
            3:    cpu_addr = SEG_ADDR;
            4:    cpu_addr = STAT_ADDR;
            5:    cpu_addr = $urandom_range(STAT_ADDR + 1, DOT_X_BASE - 1);
            6, 7: cpu_addr = DOT_X_BASE + $urandom_range(0, N_DOTS - 1);
            8, 9: cpu_addr = DOT_Y_BASE + $urandom_range(0, N_DOTS - 1);
            10:   cpu_addr = ($urandom_range(0, 1) != 0) ? DOT_X_BASE + N_DOTS - 1 : DOT_Y_BASE + N_DOTS - 1;
            default: cpu_addr = ($urandom_range(0, 1) != 0) ? DOT_Y_BASE + N_DOTS : $urandom;
        endcase
        cpu_wdata = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        cpu_wren  = ($urandom_range(0, 1) != 0);
        ram_rdata = $urandom;
        if ($urandom_range(0, 2) == 0) inc_seg = ~inc_seg;
        dot_ready = ($urandom_range(0, 99) < ready_pct);
        step();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_seg", seg_value, 0);
        chk("rst_valid", dot_valid, 0);
        chk("rst_overflow", fifo_overflow, 0);
        chk("rst_head", {dot_is_y, dot_id, dot_loc}, 0);
        reset = 1'b1;

        // RNG register / RAM alias at RNG_ADDR
        cpu_addr  = RNG_ADDR;
        ram_rdata = 32'hCAFE_0001;
        #1;
`ifdef MMIO_RNG_EN
        chk("rng_first", cpu_rdata, 32'h1);
        step();
        chk("rng_second", cpu_rdata, 32'h8020_0003);
        step();
        wr(RNG_ADDR, 32'd0);
        #1;
        chk("rng_zero_seed", cpu_rdata, 32'h1);
`else
        chk("rng_as_ram_rd", cpu_rdata, 32'hCAFE_0001);
        cpu_wren = 1'b1;
        #1;
        chk("rng_as_ram_wr", ram_wren, 1);
        step();
        cpu_wren = 1'b0;
`endif

        // generation counter: three pulses, then load and wrap
        for (int k = 0; k < 3; k++) begin
            inc_seg = 1'b1;
            repeat (5) step();
            inc_seg = 1'b0;
            repeat (3) step();
        end
        chk("seg_three", seg_value, 3);
        wr(SEG_ADDR, 32'h3FFF);
        #1;
        chk("seg_load", seg_value, 14'h3FFF);
        inc_seg = 1'b1;
        step();
        inc_seg = 1'b0;
        step();
        chk("seg_wrap", seg_value, 0);

        // fill past full with no consumer
        dot_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(DOT_X_BASE + i, 32'h100 + i);
        cpu_addr = STAT_ADDR;
        #1;
        chk("full_valid", dot_valid, 1);
        chk("full_stat", cpu_rdata, 32'h11);
        chk("full_head_loc", dot_loc, 32'h100);
        wr(STAT_ADDR, 32'h1);
        #1;
        chk("ovf_cleared", fifo_overflow, 0);

        // full with simultaneous pop and push
        dot_ready = 1'b1;
        wr(DOT_X_BASE + 1, 32'h777);
        dot_ready = 1'b0;
        cpu_addr = STAT_ADDR;
        #1;
        chk("full_pop_push_stat", cpu_rdata, 32'h10);
        chk("full_pop_push_head", dot_id, 1);
        dot_ready = 1'b1;
        repeat (10) step();
        chk("drained", dot_valid, 0);

        // Y write falls through then pops
        wr(DOT_Y_BASE + 12, 32'h55);
        #1;
        chk("y_valid", dot_valid, 1);
        chk("y_is_y", dot_is_y, 1);
        chk("y_id", dot_id, 12);
        chk("y_loc", dot_loc, 32'h55);
        step();
        chk("y_popped", dot_valid, 0);

        // RAM and unmapped stores
        cpu_addr = 100;
        cpu_wdata = 32'hAB;
        cpu_wren = 1'b1;
        #1;
        chk("ram_wren_on", ram_wren, 1);
        step();
        cpu_addr = 9995;
        ram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("unmapped_wren", ram_wren, 0);
        chk("unmapped_rdata", cpu_rdata, 0);
        step();
        cpu_wren = 1'b0;

        // randomized traffic: a backed-up phase then a draining phase
        repeat (1500) rand_cycle(20);
        repeat (1500) rand_cycle(80);

        // reset in the middle of traffic
        cpu_wren = 1'b0;
        dot_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) wr(DOT_Y_BASE + i, 32'hA0 + i);
        #1;
        chk("pre_reset_valid", dot_valid, 1);
        reset = 1'b0;
        #1;
        chk("reset_valid_drop", dot_valid, 0);
        chk("reset_head_zero", {dot_is_y, dot_id, dot_loc}, 0);
        repeat (2) step();
        reset = 1'b1;
        repeat (300) rand_cycle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub between the processor data-memory port and the data RAM, seven-segment display and VGA dot engine. It decodes the data address into RAM, random-number, generation-counter, status and dot-location regions. Dot-location writes are buffered in a FIFO with a valid/ready handshake toward the VGA block. The generation counter is synchronous, edge-detected and loadable, replacing a counter clocked directly by a processor signal.

## Interface
- `RNG_ADDR`, default 9990: word address of the LFSR register.
- `SEG_ADDR`, default 9991: generation counter address.
- `STAT_ADDR`, default 9992: status register address.
- `DOT_X_BASE`, default 10240: first X-location address.
- `DOT_Y_BASE`, default 12288: first Y-location address.
- `N_DOTS`, default 2048: dots per axis; power of 2, ≥ 2.
- `FIFO_DEPTH`, default 8: dot FIFO entries; power of 2, ≥ 2.
- `SEG_W`, default 14: generation counter width, ≤ 32.
- `RNG_SEED`, default 32'h0000_0001: LFSR reset and fallback seed; must be non-zero.
- `clock` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_addr` in 32: processor data address.
- `cpu_wdata` in 32: processor store data.
- `cpu_wren` in 1: processor store strobe.
- `cpu_rdata` out 32: load data returned to the processor.
- `ram_rdata` in 32: data RAM read data.
- `ram_wren` out 1: data RAM write enable (gated).
- `inc_seg` in 1: generation-increment level from the processor.
- `seg_value` out SEG_W: current generation count.
- `dot_valid` out 1: FIFO head is valid.
- `dot_ready` in 1: VGA block accepts the head entry.
- `dot_is_y` out 1: head entry is a Y location.
- `dot_id` out log2(N_DOTS): head entry dot index.
- `dot_loc` out 32: head entry location value.
- `fifo_overflow` out 1: sticky flag, a dot write was dropped.

## Operation
- Region decode is combinational on `cpu_addr`:
  - RAM: address < `RNG_ADDR`.
  - RNG, SEG, STAT: exact match on their addresses.
  - DOTX: address in [`DOT_X_BASE`, `DOT_X_BASE`+`N_DOTS`).
  - DOTY: address in [`DOT_Y_BASE`, `DOT_Y_BASE`+`N_DOTS`).
  - Any other address is unmapped: writes are ignored, reads return 0.
- `ram_wren` = `cpu_wren` & RAM region.
- `cpu_rdata` is a combinational mux with no added latency:
  - RAM region → `ram_rdata`.
  - RNG → LFSR state.
  - SEG → counter, zero-extended.
  - STAT → {27'b0, count[3:0], overflow}; count saturates at 15 in this field.
  - DOTX, DOTY or unmapped → 0.
- RNG:
  - 32-bit Galois LFSR, tap mask 32'h8020_0003. Free-running: it steps every cycle.
  - A write to RNG loads `cpu_wdata`. A write of 0 loads `RNG_SEED` instead. The LFSR never holds 0.
- Generation counter:
  - `inc_seg` is registered once. A rising edge (current 1, previous 0) increments the counter modulo 2^SEG_W.
  - A write to SEG loads `cpu_wdata[SEG_W-1:0]`.
  - Load and increment in the same cycle: load wins and the increment is lost.
  - `seg_value` is the counter register.
- Status: a write to STAT with `cpu_wdata[0]`=1 clears `fifo_overflow`.
- Dot FIFO:
  - Push condition: `cpu_wren` & (DOTX | DOTY).
  - Entry = {is_y, address − base, `cpu_wdata`}.
  - First-word-fall-through: `dot_valid` = not empty; head fields are driven directly from storage.
  - Pop condition: `dot_valid` & `dot_ready`.
  - Full, no pop: push is dropped and `fifo_overflow` sets.
  - Full with pop in the same cycle: push is accepted and count is unchanged.
  - Empty: a pop is impossible; push makes `dot_valid` high the next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. Count range is 0..`FIFO_DEPTH`.
  - Overflow set and clear in the same cycle: set wins.
  - Head fields are held stable while `dot_valid` & !`dot_ready`.

## Timing
- Reset (asynchronous, active-low) gives:
  - LFSR = `RNG_SEED`; counter = 0; registered `inc_seg` = 0.
  - FIFO empty; `dot_valid` = 0; `fifo_overflow` = 0.
  - `dot_is_y`, `dot_id`, `dot_loc` = 0.
- Reset mid-operation discards all FIFO contents immediately.
- Latency, all in cycles:
  - Store to any register: effective at the next edge.
  - RNG read: combinational from the current state.
  - `inc_seg` rising to `seg_value` change: 2 edges.
  - Dot write to `dot_valid`: 1 edge.
- `ram_wren` and `cpu_rdata` are purely combinational; there are no extra pipeline stages.

## Configuration
- `MMIO_RNG_EN`:
  - Defined: the LFSR is present as described above.
  - Undefined: there is no LFSR logic. `RNG_ADDR` decodes as RAM: reads return `ram_rdata` and writes assert `ram_wren`.

## Test plan
- Reset, then read address 9990 on consecutive cycles → values 0x1, then its LFSR successor 0x80200003, etc. Write 0 to 9990 → next read is 0x1.
- Pulse `inc_seg` high for 5 cycles, three separate times → `seg_value`=3. Write 0x3FFF to 9991, then one rising edge → `seg_value`=0 (wrap).
- With `dot_ready`=0, write 9 dot locations to 10240..10248 → `dot_valid`=1, STAT reads 0x11 (count 8, overflow 1). Write 1 to 9992 → `fifo_overflow`=0.
- Write 0x55 to 12300 with `dot_ready`=1 → next cycle `dot_is_y`=1, `dot_id`=12, `dot_loc`=0x55. The entry pops one cycle later.
- FIFO full with `dot_ready`=1 and a simultaneous dot write → no overflow, count stays 8.
- Write 0xAB to address 100 → `ram_wren`=1. Write to 9995 → `ram_wren`=0 and reads return 0. Assert reset mid-stream → `dot_valid` falls immediately.
